// File: rtl/decode_queue_pkg.sv
// ---------------------------------------------------------------------------
// decode_queue_pkg
// Shared pipeline definitions for the fetch/decode/execute slice:
//   - F6_* primary opcode constants (instr[31:26])
//   - q_entry_t : one buffered fetch entry {pc_plus_4, instr}
//   - imm_ext_t : immediate extension style chosen by the decoder
//   - dec_ctrl_t: decoded control bundle produced by decode_ctrl
// No ports; imported by decode_ctrl and decode_queue.
// ---------------------------------------------------------------------------
package decode_queue_pkg;

    // Widest PC/data path a queue entry can carry; narrower XLEN values
    // store their PC zero-extended into this field.
    localparam int XLEN_MAX = 64;

    localparam logic [5:0] F6_RTYPE = 6'h00;
    localparam logic [5:0] F6_J     = 6'h02;
    localparam logic [5:0] F6_JAL   = 6'h03;
    localparam logic [5:0] F6_BEQ   = 6'h04;
    localparam logic [5:0] F6_BNE   = 6'h05;
    localparam logic [5:0] F6_ADDI  = 6'h08;
    localparam logic [5:0] F6_ANDI  = 6'h0C;
    localparam logic [5:0] F6_ORI   = 6'h0D;
    localparam logic [5:0] F6_LUI   = 6'h0F;
    localparam logic [5:0] F6_LW    = 6'h23;
    localparam logic [5:0] F6_SW    = 6'h2B;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc_plus_4;
        logic [31:0]         instr;
    } q_entry_t;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } imm_ext_t;

    // reads_rs/reads_rt are internal hints for the load-use interlock and
    // are not presented to execute.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic       illegal;
        logic       reads_rs;
        logic       reads_rt;
        logic [4:0] wa;
        logic [5:0] alu_op;
    } dec_ctrl_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/decode_queue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl
// Purely combinational decoder: instruction word -> dec_ctrl_t + imm32.
// Ports:
//   instr  in  32    instruction word to decode
//   ctrl   out       decoded control bundle (dec_ctrl_t)
//   imm32  out XLEN  extended immediate
// ---------------------------------------------------------------------------
module decode_ctrl
    import decode_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output dec_ctrl_t       ctrl,
    output logic [XLEN-1:0] imm32
);

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [15:0] imm16;
    imm_ext_t    ext;

    assign op    = opcode_of(instr);
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign func  = instr[5:0];
    assign imm16 = instr[15:0];

    // Control decode. Destination defaults to rt and the ALU op to the
    // primary opcode; R-type and JAL override these. A zero destination
    // never writes, which also makes the all-zero word a clean NOP.
    always_comb begin
        ctrl        = '0;
        ctrl.wa     = rt;
        ctrl.alu_op = op;
        ext         = EXT_SIGN;
        case (op)
            F6_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reads_rs  = 1'b1;
                ctrl.reads_rt  = 1'b1;
                ctrl.wa        = rd;
                ctrl.alu_op    = func;
            end
            F6_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reads_rs  = 1'b1;
            end
            F6_ANDI, F6_ORI: begin
                ext            = EXT_ZERO;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reads_rs  = 1'b1;
            end
            F6_LUI: begin
                ext            = EXT_UPPER;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            F6_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.reads_rs   = 1'b1;
            end
            F6_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.reads_rs  = 1'b1;
                ctrl.reads_rt  = 1'b1;
            end
            F6_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.reads_rs = 1'b1;
                ctrl.reads_rt = 1'b1;
            end
            F6_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.reads_rs  = 1'b1;
                ctrl.reads_rt  = 1'b1;
            end
            F6_J: begin
                ctrl.jump = 1'b1;
            end
            F6_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.link      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.wa        = LINK_REG;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (ctrl.wa == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

    // Immediate extension to the full data-path width.
    always_comb begin
        imm32 = {{(XLEN-16){imm16[15]}}, imm16};
        case (ext)
            EXT_ZERO:  imm32 = XLEN'(imm16);
            EXT_UPPER: imm32 = XLEN'({imm16, 16'h0000});
            default:   imm32 = {{(XLEN-16){imm16[15]}}, imm16};
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
// DEPTH-entry instruction FIFO between fetch and execute that decodes its
// head entry, with valid/ready on both sides and a one-cycle load-use
// interlock.
// Ports:
//   clk, resetn                clock, async active-low reset
//   flush                      drop all queued entries and interlock state
//   in_valid/in_ready          fetch-side handshake
//   in_pc_plus_4, in_instr     offered fetch entry
//   rf_ra1/rf_ra2              register-file read addresses (head rs/rt)
//   rf_rd1/rf_rd2              register-file read data (combinational)
//   out_valid/out_ready        execute-side handshake
//   out_pc_plus_4 .. out_alu_op  decoded head fields
//   out_reg_write .. out_illegal decoded head control flags
// ---------------------------------------------------------------------------
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc_plus_4,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_wa,
    output logic [XLEN-1:0] out_imm32,
    output logic [25:0]     out_offset,
    output logic [5:0]      out_alu_op,
    output logic            out_reg_write,
    output logic            out_mem_to_reg,
    output logic            out_mem_write,
    output logic            out_alu_src,
    output logic            out_branch,
    output logic            out_branch_ne,
    output logic            out_jump,
    output logic            out_link,
    output logic            out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             last_lw;
    logic [4:0]       last_rt;

    q_entry_t         head;
    dec_ctrl_t        ctrl;
    logic [4:0]       head_rs;
    logic [4:0]       head_rt;
    logic             push;
    logic             pop;
    logic             lu_hold;

    assign head    = mem[rd_ptr];
    assign head_rs = head.instr[25:21];
    assign head_rt = head.instr[20:16];

    // in_ready looks only at occupancy, so a full queue refuses a push even
    // in a cycle where execute drains the head.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0) && !lu_hold;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // The load leaving last cycle has not produced its data yet; hold the
    // head back one cycle if it reads that load's destination.
    assign lu_hold = LOAD_USE_STALL && last_lw && (last_rt != 5'd0) &&
                     ((ctrl.reads_rs && (head_rs == last_rt)) ||
                      (ctrl.reads_rt && (head_rt == last_rt)));

    decode_ctrl #(
        .XLEN (XLEN)
    ) u_decode_ctrl (
        .instr (head.instr),
        .ctrl  (ctrl),
        .imm32 (out_imm32)
    );

    // Entry storage; cleared on reset so an empty queue decodes as NOP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{pc_plus_4: XLEN_MAX'(in_pc_plus_4), instr: in_instr};
        end
    end

    // Pointers and occupancy. Flush collapses the queue by moving the read
    // pointer onto the write pointer; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Load tracker: remembers only the instruction popped on the previous
    // edge, so any non-pop cycle (including the hold itself) releases it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_lw <= 1'b0;
            last_rt <= 5'd0;
        end else if (pop) begin
            last_lw <= (opcode_of(head.instr) == F6_LW);
            last_rt <= head_rt;
        end else begin
            last_lw <= 1'b0;
            last_rt <= 5'd0;
        end
    end

    // PC bits above XLEN are always zero in storage.
    generate
        if (XLEN < XLEN_MAX) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = |head.pc_plus_4[XLEN_MAX-1:XLEN];
        end
    endgenerate

    assign rf_ra1         = head_rs;
    assign rf_ra2         = head_rt;
    assign out_pc_plus_4  = head.pc_plus_4[XLEN-1:0];
    assign out_rd1        = rf_rd1;
    assign out_rd2        = rf_rd2;
    assign out_rs         = head_rs;
    assign out_rt         = head_rt;
    assign out_rd         = head.instr[15:11];
    assign out_offset     = head.instr[25:0];
    assign out_wa         = ctrl.wa;
    assign out_alu_op     = ctrl.alu_op;
    assign out_reg_write  = ctrl.reg_write;
    assign out_mem_to_reg = ctrl.mem_to_reg;
    assign out_mem_write  = ctrl.mem_write;
    assign out_alu_src    = ctrl.alu_src;
    assign out_branch     = ctrl.branch;
    assign out_branch_ne  = ctrl.branch_ne;
    assign out_jump       = ctrl.jump;
    assign out_link       = ctrl.link;
    assign out_illegal    = ctrl.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
// Directed testbench for decode_queue at default parameters.
// ---------------------------------------------------------------------------
module tb_decode_queue;

    localparam int XLEN = 32;

    logic            clk;
    logic            resetn;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc_plus_4;
    logic [31:0]     in_instr;
    logic [4:0]      rf_ra1;
    logic [4:0]      rf_ra2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc_plus_4;
    logic [XLEN-1:0] out_rd1;
    logic [XLEN-1:0] out_rd2;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_wa;
    logic [XLEN-1:0] out_imm32;
    logic [25:0]     out_offset;
    logic [5:0]      out_alu_op;
    logic            out_reg_write;
    logic            out_mem_to_reg;
    logic            out_mem_write;
    logic            out_alu_src;
    logic            out_branch;
    logic            out_branch_ne;
    logic            out_jump;
    logic            out_link;
    logic            out_illegal;

    int checks   = 0;
    int failures = 0;

    decode_queue #(
        .XLEN           (XLEN),
        .DEPTH          (4),
        .LOAD_USE_STALL (1'b1)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc_plus_4   (in_pc_plus_4),
        .in_instr       (in_instr),
        .rf_ra1         (rf_ra1),
        .rf_ra2         (rf_ra2),
        .rf_rd1         (rf_rd1),
        .rf_rd2         (rf_rd2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc_plus_4  (out_pc_plus_4),
        .out_rd1        (out_rd1),
        .out_rd2        (out_rd2),
        .out_rs         (out_rs),
        .out_rt         (out_rt),
        .out_rd         (out_rd),
        .out_wa         (out_wa),
        .out_imm32      (out_imm32),
        .out_offset     (out_offset),
        .out_alu_op     (out_alu_op),
        .out_reg_write  (out_reg_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_mem_write  (out_mem_write),
        .out_alu_src    (out_alu_src),
        .out_branch     (out_branch),
        .out_branch_ne  (out_branch_ne),
        .out_jump       (out_jump),
        .out_link       (out_link),
        .out_illegal    (out_illegal)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register-file model: read data tags the address so pass-through is visible.
    assign rf_rd1 = 32'hA000_0000 | {27'd0, rf_ra1};
    assign rf_rd2 = 32'hB000_0000 | {27'd0, rf_ra2};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle's worth of inputs and lets combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid     = iv;
        in_instr     = instr;
        in_pc_plus_4 = pc;
        out_ready    = ordy;
        flush        = fl;
        #1;
    endtask

    // Advances past the next rising edge so outputs are sampled off the edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        stepClock();
        stepClock();

        // Reset state: empty, ready, NOP decode.
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_ctrl", 64'({out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src,
                    out_branch, out_branch_ne, out_jump, out_link, out_illegal}), 64'h0);
        checkOutput("rst_fields", 64'({out_rs, out_rt, out_rd, out_wa, out_alu_op, out_offset}), 64'h0);
        checkOutput("rst_imm_pc", {out_imm32, out_pc_plus_4}, 64'h0);
        checkOutput("rst_ra", 64'({rf_ra1, rf_ra2}), 64'h0);

        resetn = 1'b1;
        stepClock();

        // Fill: four ADDI $8,$0,i+1 with execute stalled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h2008_0001 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            checkOutput("fill_in_ready", 64'(in_ready), 64'h1);
            checkOutput("fill_out_valid", 64'(out_valid), (i == 0) ? 64'h0 : 64'h1);
            stepClock();
        end
        applyStimulus(1'b1, 32'h2008_0005, 32'h114, 1'b0, 1'b0);
        checkOutput("full_in_ready", 64'(in_ready), 64'h0);
        stepClock();

        // Drain in order; the refused 5th word must never appear.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 0, 32'h2008_0005, 32'h114, 1'b1, 1'b0);
            if (i == 0) begin
                checkOutput("full_pop_in_ready", 64'(in_ready), 64'h0);
            end
            checkOutput("drain_valid", 64'(out_valid), 64'h1);
            checkOutput("drain_pc", 64'(out_pc_plus_4), 64'h100 + 64'(4 * i));
            checkOutput("drain_imm", 64'(out_imm32), 64'(i + 1));
            stepClock();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(out_valid), 64'h0);

        // ADDI $8,$0,-1 streamed through.
        applyStimulus(1'b1, 32'h2008_FFFF, 32'h204, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("addi_valid", 64'(out_valid), 64'h1);
        checkOutput("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
        checkOutput("addi_wa", 64'(out_wa), 64'd8);
        checkOutput("addi_ctrl", 64'({out_reg_write, out_alu_src, out_mem_to_reg, out_illegal}), 64'b1100);
        checkOutput("addi_alu_op", 64'(out_alu_op), 64'h08);
        stepClock();

        // ORI zero-extends; LUI pushed while ORI pops.
        applyStimulus(1'b1, 32'h3508_FFFF, 32'h208, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h3C08_1234, 32'h20C, 1'b1, 1'b0);
        checkOutput("ori_imm", 64'(out_imm32), 64'h0000_FFFF);
        checkOutput("ori_alu_op", 64'(out_alu_op), 64'h0D);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("lui_valid", 64'(out_valid), 64'h1);
        checkOutput("lui_imm", 64'(out_imm32), 64'h1234_0000);
        checkOutput("lui_pc", 64'(out_pc_plus_4), 64'h20C);
        stepClock();
        checkOutput("lui_empty", 64'(out_valid), 64'h0);

        // LW $9,0($0) then ADD $10,$9,$9: one-cycle hold.
        applyStimulus(1'b1, 32'h8C09_0000, 32'h300, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h0129_5020, 32'h304, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("lw_valid", 64'(out_valid), 64'h1);
        checkOutput("lw_ctrl", 64'({out_mem_to_reg, out_reg_write, out_alu_src, out_mem_write}), 64'b1110);
        checkOutput("lw_wa", 64'(out_wa), 64'd9);
        stepClock();
        checkOutput("lu_hold", 64'(out_valid), 64'h0);
        stepClock();
        checkOutput("lu_release", 64'(out_valid), 64'h1);
        checkOutput("add_wa", 64'(out_wa), 64'd10);
        checkOutput("add_rd_data", {out_rd1, out_rd2}, 64'hA000_0009_B000_0009);
        checkOutput("add_fields", 64'({out_rs, out_rt, out_rd, out_alu_op}), 64'({5'd9, 5'd9, 5'd10, 6'h20}));
        stepClock();

        // LW $9 then ADD $10,$0,$0: no dependence, no hold.
        applyStimulus(1'b1, 32'h8C09_0000, 32'h308, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h0000_5020, 32'h30C, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkOutput("no_hold_valid", 64'(out_valid), 64'h1);
        checkOutput("no_hold_pc", 64'(out_pc_plus_4), 64'h30C);
        stepClock();
        checkOutput("no_hold_empty", 64'(out_valid), 64'h0);

        // BNE, SW, ORI, ORI queued; pop BNE, then flush three entries.
        applyStimulus(1'b1, 32'h1509_FFFE, 32'h500, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'hAD09_0004, 32'h504, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h3408_0001, 32'h508, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h3408_0002, 32'h50C, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("bne_ctrl", 64'({out_branch, out_branch_ne, out_reg_write}), 64'b110);
        checkOutput("bne_imm", 64'(out_imm32), 64'hFFFF_FFFE);
        stepClock();
        applyStimulus(1'b1, 32'h3408_0099, 32'h510, 1'b1, 1'b1);
        checkOutput("sw_ctrl", 64'({out_mem_write, out_alu_src, out_reg_write, out_branch}), 64'b1100);
        checkOutput("sw_imm", 64'(out_imm32), 64'h4);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_valid", 64'(out_valid), 64'h0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 32'h0800_0005, 32'h600, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("j_valid", 64'(out_valid), 64'h1);
        checkOutput("j_ctrl", 64'({out_jump, out_link, out_reg_write}), 64'b100);
        checkOutput("j_offset", 64'(out_offset), 64'h5);
        stepClock();
        checkOutput("flush_word_absent", 64'(out_valid), 64'h0);

        // JAL then an illegal opcode 0x3F.
        applyStimulus(1'b1, 32'h0C00_0010, 32'h400, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'hFC00_0000, 32'h404, 1'b1, 1'b0);
        checkOutput("jal_ctrl", 64'({out_jump, out_link, out_reg_write, out_illegal}), 64'b1110);
        checkOutput("jal_wa", 64'(out_wa), 64'd31);
        checkOutput("jal_offset", 64'(out_offset), 64'h10);
        checkOutput("jal_alu_op", 64'(out_alu_op), 64'h03);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("ill_valid", 64'(out_valid), 64'h1);
        checkOutput("ill_ctrl", 64'({out_illegal, out_reg_write, out_jump, out_alu_src}), 64'b1000);
        checkOutput("ill_alu_op", 64'(out_alu_op), 64'h3F);
        stepClock();
        checkOutput("final_empty", 64'(out_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-entry decode stage.
- Sits between fetch and execute. Buffers up to DEPTH fetched instructions in a FIFO and decodes the head entry.
- Uses valid/ready handshakes on both sides instead of external stall/flush-hold wiring.
- Adds a wider opcode set, a resolved write-destination field, an illegal-instruction flag and an internal load-use interlock.

Parameters:
- XLEN, 32, width of PC and data paths.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LOAD_USE_STALL, 1, when 1 enables the one-cycle load-use interlock; when 0 the interlock is disabled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  discards all queued entries and interlock state.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_pc_plus_4  in  XLEN  PC+4 of the offered instruction.
- in_instr  in  32  offered instruction word.
- rf_ra1, rf_ra2  out  5  register-file read addresses (head rs, head rt).
- rf_rd1, rf_rd2  in  XLEN  register-file read data, combinational.
- out_valid  out  1  decoded head is presented to execute.
- out_ready  in  1  execute accepts the head this cycle.
- out_pc_plus_4  out  XLEN  head PC+4.
- out_rd1, out_rd2  out  XLEN  pass-through of rf_rd1, rf_rd2.
- out_rs, out_rt, out_rd  out  5 each  instruction fields [25:21], [20:16], [15:11].
- out_wa  out  5  resolved destination: rd for R-type, 31 for JAL, rt otherwise.
- out_imm32  out  XLEN  extended immediate.
- out_offset  out  26  instruction field [25:0].
- out_alu_op  out  6  func for R-type, opcode otherwise.
- out_reg_write, out_mem_to_reg, out_mem_write, out_alu_src, out_branch, out_branch_ne, out_jump, out_link, out_illegal  out  1 each  control flags.

Behaviour:
- **Reset.** resetn low clears read pointer, write pointer, occupancy count, load tracker and all entry storage to 0. During reset: in_ready=1, out_valid=0, and every decoded output is 0 (an all-zero entry decodes to NOP).
- **Push.** Occurs on a posedge when in_valid && in_ready && !flush.
- **in_ready.** in_ready = (count != DEPTH). It has no combinational dependence on out_ready, so a full queue refuses push even when a pop happens in the same cycle.
- **Pop.** Occurs on a posedge when out_valid && out_ready && !flush.
- **out_valid.** out_valid = (count != 0) && !lu_hold.
- **Simultaneous push and pop.** count is unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- **Latency.** An instruction pushed at edge N is presentable from cycle N+1 when the queue was empty; there is no bypass.
- **Flush.** Has priority over push and pop. The next posedge sets count=0, equalises the pointers and clears the load tracker. Data pushed in that cycle is discarded.
- **Load tracker.** On every pop, record last_lw=(popped op==LW) and last_rt=popped rt.
- **Load-use hold.** lu_hold = LOAD_USE_STALL && last_lw && last_rt!=0 && head reads last_rt. An instruction reads rs when it is R-type, ADDI, ANDI, ORI, LW, SW, BEQ or BNE. It reads rt when it is R-type, SW, BEQ or BNE.
  - The tracker clears on any cycle in which no pop occurs. The hold therefore lasts exactly one cycle after the load leaves.
- **Decode of the head entry** (combinational):
  - NOP (word 0): all controls 0.
  - R-type (op 0): reg_write=1, reg_dst semantics via out_wa.
  - ADDI 0x08: sign-extend, alu_src=1, reg_write=1.
  - ANDI 0x0C, ORI 0x0D: zero-extend, alu_src=1, reg_write=1.
  - LUI 0x0F: imm32={imm16,16'b0}, alu_src=1, reg_write=1.
  - LW 0x23: sign-extend, alu_src=1, mem_to_reg=1, reg_write=1.
  - SW 0x2B: sign-extend, alu_src=1, mem_write=1.
  - BEQ 0x04: sign-extend, branch=1.
  - BNE 0x05: sign-extend, branch=1, branch_ne=1.
  - J 0x02: jump=1.
  - JAL 0x03: jump=1, link=1, reg_write=1, out_wa=31.
  - Any other opcode: illegal=1, all other controls 0, out_valid still asserted so execute can trap.
- **Widths.** imm32 extension fills to XLEN. reg_write is forced to 0 whenever out_wa==0.

Decomposition:
- Shared pipes package:
  - opcode constants F6_ANDI, F6_ORI, F6_LUI, F6_BNE, F6_JAL, added alongside the existing F6_* constants;
  - q_entry_t {pc_plus_4, instr};
  - a decoded-control struct dec_ctrl_t.
- One sub-module, decode_ctrl: purely combinational instruction-to-dec_ctrl_t plus imm32. The FIFO, counters and interlock stay in decode_queue.

Test Plan:
- **Reset and fill.** Reset, then push 4 instructions with out_ready=0 → in_ready falls after the 4th push. A 5th push is refused and count stays 4.
- **Pipelined stream.** Push ADDI $8,$0,-1 (0x2008FFFF) with out_ready=1 → next cycle out_valid=1, imm32=0xFFFFFFFF, out_wa=8, reg_write=1, alu_src=1.
- **Zero-extend and LUI.** Push ORI 0x3508FFFF → imm32=0x0000FFFF. Push LUI 0x3C081234 → imm32=0x12340000.
- **Load-use hold.** Pop LW $9,0($0), then head ADD $10,$9,$9 → out_valid=0 for exactly 1 cycle, then 1. With the head ADD $10,$0,$0 instead → no hold.
- **Flush.** Flush with 3 entries queued while in_valid=1 → next cycle count=0, out_valid=0, in_ready=1, and the pushed word is absent.
- **JAL and illegal.** JAL 0x0C000010 → jump=1, link=1, out_wa=31, offset=0x10. Opcode 0x3F → illegal=1, reg_write=0.
